// File: rtl/float_to_int_arbiter_if.sv
// Request/result bundle between requesters, consumer and the arbiter.
// master: requesters + consumer side; slave: float_to_int_arbiter.
interface float_to_int_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FLOAT_SIZE = 32,
  parameter int INT_SIZE   = 32,
  parameter int ID_SIZE    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*FLOAT_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          res_valid;
  logic                          res_ready;
  logic [ID_SIZE-1:0]            res_id;
  logic [INT_SIZE-1:0]           res_data;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_id, res_data
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_id, res_data
  );
endinterface

// File: rtl/float_to_int_arbiter.sv
// Round-robin sharing of one pipelined float-to-int converter, with a
// credit-checked result FIFO so results can be back-pressured.
// Ports: clk, reset (async, active-high); bus (slave): req_valid/
// req_data/req_ready, res_valid/res_ready/res_id/res_data;
// conv_in (registered converter input), conv_out (converter result).
module float_to_int_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int FLOAT_SIZE   = 32,
  parameter int INT_SIZE     = 32,
  parameter int CONV_LATENCY = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int ID_SIZE      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  float_to_int_arbiter_if.slave bus,
  output logic [FLOAT_SIZE-1:0] conv_in,
  input  logic [INT_SIZE-1:0]   conv_out
);
  localparam int NS = CONV_LATENCY + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + CONV_LATENCY + 2);

  logic [NS-1:0]       tag_v;
  logic [ID_SIZE-1:0]  tag_id [NS];
  logic [ID_SIZE-1:0]  rr_ptr;
  logic [ID_SIZE-1:0]  rr_next;
  logic [ID_SIZE-1:0]  grant;
  logic                found;
  logic                allow;
  logic                fire;
  logic [CW-1:0]       inflight;
  logic [CW-1:0]       count;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [ID_SIZE-1:0]  mem_id [FIFO_DEPTH];
  logic [INT_SIZE-1:0] mem_data [FIFO_DEPTH];
  logic                push;
  logic                pop;
  int                  idx;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every issued op owns a FIFO slot from issue to pop, so the
  // converter pipeline never has to stall.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < NS; k++)
      inflight = inflight + CW'(tag_v[k]);
  end

  assign allow = (count + inflight) < CW'(FIFO_DEPTH);

  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        grant = ID_SIZE'(idx);
      end
    end
  end

  assign fire    = found & allow & ~reset;
  assign rr_next = (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;

  always_comb begin
    bus.req_ready = '0;
    if (fire) bus.req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr  <= '0;
      conv_in <= '0;
      tag_v   <= '0;
    end else begin
      tag_v <= {tag_v[NS-2:0], fire};
      if (fire) begin
        conv_in <= bus.req_data[int'(grant)*FLOAT_SIZE +: FLOAT_SIZE];
        rr_ptr  <= rr_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_id[0] <= grant;
    for (int k = 1; k < NS; k++)
      tag_id[k] <= tag_id[k-1];
  end

  assign push = tag_v[NS-1];
  assign pop  = bus.res_valid & bus.res_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr]   <= tag_id[NS-1];
      mem_data[wr_ptr] <= conv_out;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop)  rd_ptr <= inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Empty head reads as zero so the outputs are defined after reset.
  assign bus.res_valid = (count != '0);
  assign bus.res_id    = bus.res_valid ? mem_id[rd_ptr] : '0;
  assign bus.res_data  = bus.res_valid ? mem_data[rd_ptr] : '0;
endmodule

// File: tb/tb_float_to_int_arbiter.sv
// Bench for float_to_int_arbiter: directed vectors and corner sequences,
// with a behavioural pipelined converter wired to conv_in/conv_out.
module tb_float_to_int_arbiter;
  localparam int NR  = 4;
  localparam int FS  = 32;
  localparam int IS  = 32;
  localparam int L   = 4;
  localparam int FD  = 8;
  localparam int IDW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [FS-1:0] conv_in;
  logic [IS-1:0] conv_out;

  float_to_int_arbiter_if #(
    .NUM_REQ(NR), .FLOAT_SIZE(FS), .INT_SIZE(IS), .ID_SIZE(IDW)
  ) bus ();

  float_to_int_arbiter #(
    .NUM_REQ(NR), .FLOAT_SIZE(FS), .INT_SIZE(IS),
    .CONV_LATENCY(L), .FIFO_DEPTH(FD), .ID_SIZE(IDW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .conv_in(conv_in),
    .conv_out(conv_out)
  );

  always #5 clk = ~clk;

  // Converter: round half away from zero; out of range, inf, NaN give 0.
  function automatic logic [31:0] f2i(input logic [31:0] x);
    int          e;
    logic [63:0] full;
    logic [63:0] r;
    e    = int'(x[30:23]) - 127;
    full = {40'd0, 1'b1, x[22:0]};
    if (x[30:23] == 8'hFF || e >= 31 || e < -1) r = '0;
    else if (e <= 22) r = (full + (64'd1 << (22 - e))) >> (23 - e);
    else r = full << (e - 23);
    if (r >= 64'h8000_0000) r = '0;
    return x[31] ? -r[31:0] : r[31:0];
  endfunction

  logic [IS-1:0] cpipe [L];
  always @(posedge clk) begin
    cpipe[0] <= f2i(conv_in);
    for (int k = 1; k < L; k++) cpipe[k] <= cpipe[k-1];
  end
  assign conv_out = cpipe[L-1];

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0;
  logic [IDW-1:0] got_id [$];
  logic [IS-1:0]  got_data [$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      if (bus.res_valid && bus.res_ready) begin
        got_id.push_back(bus.res_id);
        got_data.push_back(bus.res_data);
      end
      if (|(bus.req_valid & bus.req_ready)) hs_cnt++;
      if (bus.req_ready != '0)
        chk("onehot", 64'($countones(bus.req_ready)), 64'd1);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    hs_cnt = 0;
    got_id.delete();
    got_data.delete();
  endtask

  task automatic wait_got(input int n, input int lim);
    int t;
    t = 0;
    while (got_data.size() < n && t < lim) begin
      @(negedge clk);
      t++;
    end
    chk("drain_count", 64'(got_data.size()), 64'(n));
  endtask

  typedef struct {
    logic [31:0] f;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt [12];
  logic [31:0] ft [10];

  initial begin
    #100000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{32'h40490FDB, 32'h00000003};
    vt[1]  = '{32'hC0200000, 32'hFFFFFFFD};
    vt[2]  = '{32'h501502F9, 32'h00000000};
    vt[3]  = '{32'h3F000000, 32'h00000001};
    vt[4]  = '{32'h3EFFFFFF, 32'h00000000};
    vt[5]  = '{32'h00000000, 32'h00000000};
    vt[6]  = '{32'h42F6E979, 32'h0000007B};
    vt[7]  = '{32'hC2F70000, 32'hFFFFFF84};
    vt[8]  = '{32'h4F000000, 32'h00000000};
    vt[9]  = '{32'h4EFFFFFF, 32'h7FFFFF80};
    vt[10] = '{32'h3FC00000, 32'h00000002};
    vt[11] = '{32'h7F800000, 32'h00000000};
    ft = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
           32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
           32'h41100000, 32'h41200000};

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b0;

    // reset values
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_conv_in", 64'(conv_in), 64'd0);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_res_id", 64'(bus.res_id), 64'd0);
    chk("rst_res_data", 64'(bus.res_data), 64'd0);
    bus.req_valid = 4'b1111;
    #1 chk("rst_ready_held", 64'(bus.req_ready), 64'd0);
    bus.req_valid = '0;
    reset = 1'b0;

    // single request latency
    do_reset();
    @(negedge clk);
    bus.req_data[2*FS +: FS] = 32'h40490FDB;
    bus.req_valid = 4'b0100;
    #1 chk("single_ready", 64'(bus.req_ready), 64'h4);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    chk("single_conv_in", 64'(conv_in), 64'h40490FDB);
    chk("single_rv0", 64'(bus.res_valid), 64'd0);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      #1 chk($sformatf("single_lat%0d", n), 64'(bus.res_valid),
             64'(n == 5));
    end
    chk("single_id", 64'(bus.res_id), 64'd2);
    chk("single_data", 64'(bus.res_data), 64'd3);
    chk("single_hs", 64'(hs_cnt), 64'd1);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1 chk("single_popped", 64'(bus.res_valid), 64'd0);

    // table of conversions through rotating requesters
    for (int i = 0; i < 12; i++) begin
      int r;
      int t;
      r = i % NR;
      @(negedge clk);
      bus.req_valid = '0;
      bus.req_valid[r] = 1'b1;
      bus.req_data[r*FS +: FS] = vt[i].f;
      #1 chk($sformatf("vec%0d_ready", i), 64'(bus.req_ready),
             64'(1 << r));
      @(negedge clk);
      bus.req_valid = '0;
      t = 0;
      while (!bus.res_valid && t < 12) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("vec%0d_id", i), 64'(bus.res_id), 64'(r));
      chk($sformatf("vec%0d_data", i), 64'(bus.res_data), 64'(vt[i].exp));
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
    end

    // round robin at full throughput
    do_reset();
    for (int r = 0; r < NR; r++) bus.req_data[r*FS +: FS] = ft[r];
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1 chk($sformatf("rr_grant%0d", c), 64'(bus.req_ready),
             64'(1 << (c % NR)));
    end
    @(negedge clk);
    bus.req_valid = '0;
    wait_got(12, 40);
    for (int k = 0; k < 12; k++) begin
      if (got_data.size() > k) begin
        chk($sformatf("rr_id%0d", k), 64'(got_id[k]), 64'(k % NR));
        chk($sformatf("rr_data%0d", k), 64'(got_data[k]),
            64'(k % NR + 1));
      end
    end

    // back-pressure: exactly FIFO_DEPTH accepted
    do_reset();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      bus.req_valid = 4'b0001;
      bus.req_data[0 +: FS] = ft[(hs_cnt < 9) ? hs_cnt : 9];
    end
    #1;
    chk("bp_hs", 64'(hs_cnt), 64'd8);
    chk("bp_ready", 64'(bus.req_ready), 64'd0);
    chk("bp_rv", 64'(bus.res_valid), 64'd1);
    chk("bp_head_id", 64'(bus.res_id), 64'd0);
    chk("bp_head_data", 64'(bus.res_data), 64'd1);
    @(negedge clk);
    bus.res_ready = 1'b1;
    #1 chk("bp_pop_cycle_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.req_data[0 +: FS] = ft[hs_cnt];
    #1 chk("bp_regrant", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = '0;
    #1 chk("bp_hs9", 64'(hs_cnt), 64'd9);
    bus.res_ready = 1'b1;
    wait_got(9, 40);
    for (int k = 0; k < 9; k++)
      if (got_data.size() > k)
        chk($sformatf("bp_data%0d", k), 64'(got_data[k]), 64'(k + 1));

    // fairness: requester 3 raised while rr_ptr = 2
    do_reset();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 4'b0010;
    #1 chk("fair_g1", 64'(bus.req_ready), 64'h2);
    @(negedge clk);
    bus.req_valid = 4'b1010;
    #1 chk("fair_g3", 64'(bus.req_ready), 64'h8);
    @(negedge clk);
    #1 chk("fair_g1b", 64'(bus.req_ready), 64'h2);
    @(negedge clk);
    bus.req_valid = '0;
    wait_got(3, 30);
    if (got_id.size() >= 3) begin
      chk("fair_id0", 64'(got_id[0]), 64'd1);
      chk("fair_id1", 64'(got_id[1]), 64'd3);
      chk("fair_id2", 64'(got_id[2]), 64'd1);
    end

    // reset with 5 in flight and 3 buffered
    do_reset();
    bus.req_data[0 +: FS] = ft[0];
    @(negedge clk);
    bus.req_valid = 4'b0001;
    begin
      int t;
      t = 0;
      while (hs_cnt < 8 && t < 40) begin
        @(negedge clk);
        t++;
      end
    end
    chk("mid_hs", 64'(hs_cnt), 64'd8);
    chk("mid_rv_before", 64'(bus.res_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rv", 64'(bus.res_valid), 64'd0);
    chk("mid_ready", 64'(bus.req_ready), 64'd0);
    chk("mid_conv_in", 64'(conv_in), 64'd0);
    @(negedge clk);
    @(negedge clk);
    got_id.delete();
    got_data.delete();
    bus.req_valid = 4'b1001;
    bus.req_data[0 +: FS] = 32'hC0200000;
    reset = 1'b0;
    #1 chk("mid_from0", 64'(bus.req_ready), 64'h1);
    @(negedge clk);
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    repeat (15) @(negedge clk);
    chk("mid_no_stale", 64'(got_data.size()), 64'd1);
    if (got_data.size() > 0) begin
      chk("mid_id", 64'(got_id[0]), 64'd0);
      chk("mid_data", 64'(got_data[0]), 64'hFFFFFFFD);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
